stopwatch_ctrl: RTL

Control sequencer for the stopwatch `counter` block (minutes/seconds BCD digits).
- Derives the 1 Hz count enable and 2 Hz adjust enable from the board clock.
- Debounces the pause and clear buttons.
- Runs a RUN/PAUSE/ADJ state machine that tells `counter` when to advance, clear, or increment a selected field.
- Sits between the board I/O and `counter`; `counter` consumes only single-cycle pulses from this block.

---
 rtl/stopwatch_pkg.sv | 23 ++
 rtl/btn_debounce.sv | 51 +++++
 rtl/stopwatch_ctrl.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/stopwatch_pkg.sv
`default_nettype none
// ============================================================================
// stopwatch_pkg : controller state encoding and default timing constants
// Rev 1.0
// ============================================================================
package stopwatch_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_PAUSE = 2'd1,
    ST_ADJ   = 2'd2
  } state_t;

  localparam int DEF_DIV_1HZ    = 100_000_000;
  localparam int DEF_DIV_2HZ    = 50_000_000;
  localparam int DEF_DEB_CYCLES = 500_000;

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
// ============================================================================
// btn_debounce : 2-FF synchroniser, stable-level filter and press detector
// Rev 1.0
// ============================================================================
module btn_debounce
  import stopwatch_pkg::*;
#(
  parameter int DEB_CYCLES = DEF_DEB_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic level,
  output logic press
);

  localparam int             W         = cnt_width(DEB_CYCLES);
  localparam logic [W-1:0]   C_CNT_MAX = W'(DEB_CYCLES - 1);

  logic         sync1;
  logic         sync2;
  logic [W-1:0] stable_cnt;

  // stable_cnt counts consecutive cycles the synchronised input disagrees
  // with the accepted level; any agreeing cycle restarts the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1      <= 1'b0;
      sync2      <= 1'b0;
      stable_cnt <= '0;
      level      <= 1'b0;
      press      <= 1'b0;
    end else begin
      sync1 <= btn_in;
      sync2 <= sync1;
      press <= 1'b0;
      if (sync2 == level) begin
        stable_cnt <= '0;
      end else if (stable_cnt == C_CNT_MAX) begin
        stable_cnt <= '0;
        level      <= sync2;
        press      <= sync2;
      end else begin
        stable_cnt <= W'(stable_cnt + 1);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/stopwatch_ctrl.sv
`default_nettype none
// ============================================================================
// stopwatch_ctrl : RUN/PAUSE/ADJ sequencer driving the stopwatch counter.
// Optional lap/display-hold feature enabled by defining STOPWATCH_LAP_EN.
// Rev 1.0
// ============================================================================
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int DIV_1HZ    = DEF_DIV_1HZ,
  parameter int DIV_2HZ    = DEF_DIV_2HZ,
  parameter int DEB_CYCLES = DEF_DEB_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_pause,
  input  logic btn_clr,
  input  logic sw_adj,
  input  logic sw_sel,
`ifdef STOPWATCH_LAP_EN
  input  logic btn_lap,
  output logic disp_hold,
`endif
  output logic cnt_en,
  output logic cnt_clr,
  output logic adj_sec_inc,
  output logic adj_min_inc,
  output logic blink,
  output logic paused
);

  localparam int            W1         = cnt_width(DIV_1HZ);
  localparam int            W2         = cnt_width(DIV_2HZ);
  localparam logic [W1-1:0] C_PRE1_MAX = W1'(DIV_1HZ - 1);
  localparam logic [W2-1:0] C_PRE2_MAX = W2'(DIV_2HZ - 1);

  state_t        state_q, state_d;
  logic [W1-1:0] pre1_q, pre1_d;
  logic [W2-1:0] pre2_q, pre2_d;
  logic          tick1, tick2;
  logic          adj_s1, adj_s, sel_s1, sel_s;
  logic          pause_press, clr_press, pause_level, clr_level;
  logic          cnt_en_d, cnt_clr_d, sec_d, min_d, blink_d;
  logic          unused_levels;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_pause (
    .clk(clk), .rst(rst), .btn_in(btn_pause), .level(pause_level), .press(pause_press)
  );

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_clr (
    .clk(clk), .rst(rst), .btn_in(btn_clr), .level(clr_level), .press(clr_press)
  );

`ifdef STOPWATCH_LAP_EN
  logic lap_press, lap_level, hold_d;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_lap (
    .clk(clk), .rst(rst), .btn_in(btn_lap), .level(lap_level), .press(lap_press)
  );

  assign unused_levels = pause_level ^ clr_level ^ lap_level;
`else
  assign unused_levels = pause_level ^ clr_level;
`endif

  assign tick1 = (pre1_q == C_PRE1_MAX);
  assign tick2 = (pre2_q == C_PRE2_MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      adj_s1 <= 1'b0;
      adj_s  <= 1'b0;
      sel_s1 <= 1'b0;
      sel_s  <= 1'b0;
    end else begin
      adj_s1 <= sw_adj;
      adj_s  <= adj_s1;
      sel_s1 <= sw_sel;
      sel_s  <= sel_s1;
    end
  end

  // A clear press owns its cycle: no state change, no count or adjust pulse.
  always_comb begin
    state_d   = state_q;
    pre1_d    = pre1_q;
    pre2_d    = pre2_q;
    blink_d   = blink;
    cnt_en_d  = 1'b0;
    cnt_clr_d = clr_press;
    sec_d     = 1'b0;
    min_d     = 1'b0;
    if (clr_press) begin
      pre1_d = '0;
    end
    unique case (state_q)
      ST_RUN: begin
        if (!clr_press) begin
          cnt_en_d = tick1;
          pre1_d   = tick1 ? '0 : W1'(pre1_q + 1);
          if (adj_s) begin
            state_d = ST_ADJ;
            pre2_d  = '0;
          end else if (pause_press) begin
            state_d = ST_PAUSE;
          end
        end
      end
      ST_PAUSE: begin
        if (!clr_press) begin
          if (adj_s) begin
            state_d = ST_ADJ;
            pre2_d  = '0;
          end else if (pause_press) begin
            state_d = ST_RUN;
            pre1_d  = '0;
          end
        end
      end
      ST_ADJ: begin
        pre2_d = tick2 ? '0 : W2'(pre2_q + 1);
        if (tick2) begin
          blink_d = ~blink;
        end
        if (!clr_press) begin
          sec_d = tick2 & ~sel_s;
          min_d = tick2 &  sel_s;
          if (!adj_s) begin
            state_d = ST_RUN;
            pre1_d  = '0;
            blink_d = 1'b0;
          end
        end
      end
      default: begin
        state_d = ST_RUN;
        pre1_d  = '0;
        blink_d = 1'b0;
      end
    endcase
`ifdef STOPWATCH_LAP_EN
    hold_d = disp_hold;
    if (cnt_clr_d || state_d != ST_RUN) begin
      hold_d = 1'b0;
    end else if (state_q == ST_RUN && lap_press) begin
      hold_d = ~disp_hold;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_RUN;
      pre1_q      <= '0;
      pre2_q      <= '0;
      cnt_en      <= 1'b0;
      cnt_clr     <= 1'b0;
      adj_sec_inc <= 1'b0;
      adj_min_inc <= 1'b0;
      blink       <= 1'b0;
      paused      <= 1'b0;
`ifdef STOPWATCH_LAP_EN
      disp_hold   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      pre1_q      <= pre1_d;
      pre2_q      <= pre2_d;
      cnt_en      <= cnt_en_d;
      cnt_clr     <= cnt_clr_d;
      adj_sec_inc <= sec_d;
      adj_min_inc <= min_d;
      blink       <= blink_d;
      paused      <= (state_d == ST_PAUSE);
`ifdef STOPWATCH_LAP_EN
      disp_hold   <= hold_d;
`endif
    end
  end

endmodule
`default_nettype wire
